// File: rtl/flag_timestamp_buffer.sv
// Tags synchronized single-cycle flags with a free-running timestamp and
// queues the tags in a first-word-fall-through FIFO, counting overflow drops.
module flag_timestamp_buffer #(
  parameter int TS_WIDTH   = 16,
  parameter int DEPTH      = 8,
  parameter int LOST_WIDTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int FW = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic                  TS_CLEAR,
  input  logic                  LOST_CLEAR,
  input  logic                  FLAG_IN,
  output logic [TS_WIDTH-1:0]   DATA_OUT,
  output logic                  VALID,
  input  logic                  READY,
  output logic                  FULL,
  output logic [FW-1:0]         FILL_LEVEL,
  output logic [LOST_WIDTH-1:0] LOST_COUNT
);

  logic [TS_WIDTH-1:0]   ts;
  logic [TS_WIDTH-1:0]   mem [DEPTH];
  logic [PW-1:0]         wptr, rptr;
  logic [FW-1:0]         fill;
  logic [LOST_WIDTH-1:0] lost;
  logic                  flag_en, push, pop, drop;

  // Status comes only from registered fill, so no FLAG_IN/READY -> status path.
  assign FULL       = (fill == FW'(DEPTH));
  assign VALID      = (fill != '0);
  assign FILL_LEVEL = fill;
  assign LOST_COUNT = lost;
  assign DATA_OUT   = mem[rptr];

  assign flag_en = FLAG_IN & ENABLE;
  assign push    = flag_en & ~FULL;
  assign drop    = flag_en & FULL;
  assign pop     = VALID & READY;

  // Storage needs no reset; stale entries are never visible once fill is 0.
  always_ff @(posedge CLK) begin
    if (!RESET && push) mem[wptr] <= ts;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ts   <= '0;
      wptr <= '0;
      rptr <= '0;
      fill <= '0;
      lost <= '0;
    end else begin
      if (TS_CLEAR)    ts <= '0;
      else if (ENABLE) ts <= ts + TS_WIDTH'(1);

      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      fill <= fill + FW'(push) - FW'(pop);

      if (LOST_CLEAR)                           lost <= LOST_WIDTH'(drop);
      else if (drop && lost != {LOST_WIDTH{1'b1}}) lost <= lost + LOST_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_flag_timestamp_buffer.sv
// Randomized + directed bench for flag_timestamp_buffer against a queue model.
module tb_flag_timestamp_buffer;
  localparam int TSW = 5;
  localparam int DEP = 8;
  localparam int LW  = 2;
  localparam int FW  = $clog2(DEP + 1);

  logic           CLK = 1'b0;
  logic           RESET = 1'b1, ENABLE = 1'b0, TS_CLEAR = 1'b0, LOST_CLEAR = 1'b0;
  logic           FLAG_IN = 1'b0, READY = 1'b0;
  logic [TSW-1:0] DATA_OUT;
  logic           VALID, FULL;
  logic [FW-1:0]  FILL_LEVEL;
  logic [LW-1:0]  LOST_COUNT;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  flag_timestamp_buffer #(.TS_WIDTH(TSW), .DEPTH(DEP), .LOST_WIDTH(LW)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .TS_CLEAR(TS_CLEAR),
    .LOST_CLEAR(LOST_CLEAR), .FLAG_IN(FLAG_IN), .DATA_OUT(DATA_OUT),
    .VALID(VALID), .READY(READY), .FULL(FULL), .FILL_LEVEL(FILL_LEVEL),
    .LOST_COUNT(LOST_COUNT)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: a queue of timestamps plus a counter and a loss tally.
  logic [TSW-1:0] mq[$];
  int m_ts = 0;
  int m_lost = 0;

  always @(posedge CLK) begin
    bit full_now, drop;
    if (RESET) begin
      mq.delete();
      m_ts = 0;
      m_lost = 0;
    end else begin
      full_now = (mq.size() == DEP);
      drop = 1'b0;
      if (mq.size() != 0 && READY) void'(mq.pop_front());
      if (FLAG_IN && ENABLE) begin
        if (!full_now) mq.push_back(TSW'(m_ts));
        else drop = 1'b1;
      end
      if (LOST_CLEAR) m_lost = drop ? 1 : 0;
      else if (drop && m_lost < (1 << LW) - 1) m_lost = m_lost + 1;
      if (TS_CLEAR) m_ts = 0;
      else if (ENABLE) m_ts = (m_ts + 1) % (1 << TSW);
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      tests++;
      if (VALID !== (mq.size() != 0) || FULL !== (mq.size() == DEP) ||
          FILL_LEVEL !== FW'(mq.size()) || LOST_COUNT !== LW'(m_lost) ||
          (mq.size() != 0 && DATA_OUT !== mq[0])) begin
        fails++;
        $display("FAIL model: got valid=%0b full=%0b fill=%0d lost=%0d data=%0d, want valid=%0b full=%0b fill=%0d lost=%0d data=%0d",
                 VALID, FULL, FILL_LEVEL, LOST_COUNT, DATA_OUT, mq.size() != 0,
                 mq.size() == DEP, mq.size(), m_lost, (mq.size() != 0) ? int'(mq[0]) : -1);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1; ENABLE = 1'b0; TS_CLEAR = 1'b0; LOST_CLEAR = 1'b0;
    FLAG_IN = 1'b0; READY = 1'b0;
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("reset_valid", int'(VALID), 0);
    check("reset_fill", int'(FILL_LEVEL), 0);
    check("reset_lost", int'(LOST_COUNT), 0);

    // single flag at TS=5, one pop
    ENABLE = 1'b1; tick(5);
    FLAG_IN = 1'b1; tick(); FLAG_IN = 1'b0;
    check("t1_valid", int'(VALID), 1);
    check("t1_data", int'(DATA_OUT), 5);
    check("t1_fill", int'(FILL_LEVEL), 1);
    READY = 1'b1; tick(); READY = 1'b0;
    check("t1_pop_valid", int'(VALID), 0);
    check("t1_pop_fill", int'(FILL_LEVEL), 0);

    // 10 flags from TS=20 into 8 slots, then ordered drain
    do_reset(); ENABLE = 1'b1; tick(20);
    FLAG_IN = 1'b1; tick(10); FLAG_IN = 1'b0;
    check("t2_full", int'(FULL), 1);
    check("t2_lost", int'(LOST_COUNT), 2);
    READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t2_drain", int'(DATA_OUT), 20 + i);
      tick();
    end
    READY = 1'b0;
    check("t2_empty", int'(VALID), 0);

    // full + flag + pop in the same cycle
    LOST_CLEAR = 1'b1; tick(); LOST_CLEAR = 1'b0;
    FLAG_IN = 1'b1; tick(8);
    READY = 1'b1; tick(); READY = 1'b0;
    check("t3_fill", int'(FILL_LEVEL), 7);
    check("t3_lost", int'(LOST_COUNT), 1);
    tick(); FLAG_IN = 1'b0;
    check("t3_refill", int'(FILL_LEVEL), 8);

    // timestamp wrap: 30, 31, 0
    do_reset(); ENABLE = 1'b1; tick(30);
    FLAG_IN = 1'b1; tick(3); FLAG_IN = 1'b0;
    READY = 1'b1;
    check("t4_wrap0", int'(DATA_OUT), 30); tick();
    check("t4_wrap1", int'(DATA_OUT), 31); tick();
    check("t4_wrap2", int'(DATA_OUT), 0);  tick();
    READY = 1'b0;

    // TS_CLEAR alongside a flag stores the pre-clear value
    do_reset(); ENABLE = 1'b1; tick(9);
    FLAG_IN = 1'b1; TS_CLEAR = 1'b1; tick(); TS_CLEAR = 1'b0;
    tick(); FLAG_IN = 1'b0;
    READY = 1'b1;
    check("t4_clr_pre", int'(DATA_OUT), 9); tick();
    check("t4_clr_post", int'(DATA_OUT), 0); tick();
    READY = 1'b0;

    // lost counter saturation, then clear with a simultaneous drop
    do_reset(); ENABLE = 1'b1;
    FLAG_IN = 1'b1; tick(13);
    check("t5_sat", int'(LOST_COUNT), 3);
    LOST_CLEAR = 1'b1; tick(); LOST_CLEAR = 1'b0; FLAG_IN = 1'b0;
    check("t5_clr_drop", int'(LOST_COUNT), 1);

    // reset with stored entries and a flag present; then ENABLE=0 flag
    do_reset(); ENABLE = 1'b1;
    FLAG_IN = 1'b1; tick(3);
    RESET = 1'b1; tick(); RESET = 1'b0;
    check("t6_rst_valid", int'(VALID), 0);
    check("t6_rst_fill", int'(FILL_LEVEL), 0);
    ENABLE = 1'b0; tick();
    check("t6_dis_fill", int'(FILL_LEVEL), 0);
    check("t6_dis_lost", int'(LOST_COUNT), 0);
    ENABLE = 1'b1; tick(); FLAG_IN = 1'b0;
    check("t6_ts_zero", int'(DATA_OUT), 0);

    // random traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      RESET      = ($urandom_range(0, 199) == 0);
      ENABLE     = ($urandom_range(0, 9) != 0);
      TS_CLEAR   = ($urandom_range(0, 49) == 0);
      LOST_CLEAR = ($urandom_range(0, 29) == 0);
      FLAG_IN    = ($urandom_range(0, 99) < ((i / 300) % 2 ? 70 : 35));
      READY      = ($urandom_range(0, 99) < ((i / 300) % 2 ? 30 : 65));
      tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/flag_timestamp_buffer.md
Name: flag_timestamp_buffer

Overview:
- Consumes single-cycle flags that have already been synchronized into this clock domain (the output of the flag domain-crossing stage).
- Tags each flag with the value of a free-running timestamp counter.
- Buffers the tags in a small first-word-fall-through FIFO read through a VALID/READY handshake.
- Counts flags dropped while the FIFO is full.

Parameters:
- TS_WIDTH, 16, width of timestamp counter and DATA_OUT.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- LOST_WIDTH, 8, width of saturating lost-flag counter.

Ports:
- CLK  input  1  single clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- ENABLE  input  1  gates timestamp counting and flag capture.
- TS_CLEAR  input  1  synchronous timestamp counter clear.
- LOST_CLEAR  input  1  synchronous lost-counter clear.
- FLAG_IN  input  1  one-cycle event flag.
- DATA_OUT  output  TS_WIDTH  timestamp at the head of the FIFO.
- VALID  output  1  FIFO non-empty; DATA_OUT meaningful.
- READY  input  1  consumer accepts head when VALID.
- FULL  output  1  FIFO holds DEPTH entries.
- FILL_LEVEL  output  clog2(DEPTH+1)  current entry count.
- LOST_COUNT  output  LOST_WIDTH  flags dropped while full, saturating.

Behaviour:
- Reset (RESET=1 at a rising edge):
  - Timestamp counter TS=0, FIFO emptied, pointers=0.
  - VALID=0, FULL=0, FILL_LEVEL=0, LOST_COUNT=0.
  - DATA_OUT is don't-care.
  - RESET has priority over every other input. Asserting it mid-operation discards all stored entries. A flag in the reset cycle is ignored.
- Timestamp counter:
  - TS increments by 1 each cycle with ENABLE=1 and wraps from 2^TS_WIDTH-1 to 0.
  - It holds while ENABLE=0.
  - TS_CLEAR=1 forces TS=0 at the next edge, regardless of ENABLE.
- Capture:
  - A flag is accepted in cycle n when FLAG_IN=1, ENABLE=1 and FULL=0. The stored value is the TS value during cycle n, i.e. the pre-increment and pre-clear value.
  - FLAG_IN while ENABLE=0 is ignored and not counted as lost.
- Latency: a flag accepted in cycle n with the FIFO empty gives VALID=1 and DATA_OUT=stored TS in cycle n+1.
- Read:
  - The head is popped when VALID=1 and READY=1 at an edge.
  - DATA_OUT and VALID must remain stable while VALID=1 and READY=0.
  - READY while VALID=0 has no effect.
- Simultaneous write and pop:
  - When not full: both occur and FILL_LEVEL is unchanged.
  - When full: the flag is dropped (FULL is evaluated before the pop) and the pop still happens.
- Overflow: a flag with ENABLE=1 and FULL=1 increments LOST_COUNT, saturating at 2^LOST_WIDTH-1.
- LOST_CLEAR:
  - LOST_CLEAR=1 sets LOST_COUNT=0.
  - If a drop happens in the same cycle, the result is 1.
- Status outputs:
  - FULL = (FILL_LEVEL==DEPTH).
  - VALID = (FILL_LEVEL!=0).
  - Both are registered or derived from registered state; no combinational path from FLAG_IN or READY.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Ordering is strictly FIFO across the wrap.
- Back-to-back flags: a flag in every cycle is accepted while FIFO space remains. The stored timestamps are consecutive.

Test Plan:
- Reset, ENABLE=1, FLAG_IN pulse at cycle with TS=5, READY=0 -> next cycle VALID=1, DATA_OUT=5, FILL_LEVEL=1; READY=1 one cycle -> VALID=0, FILL_LEVEL=0.
- DEPTH=8, READY=0, 10 consecutive flags starting at TS=20 -> FIFO holds 20..27, FULL=1, LOST_COUNT=2; drain with READY=1 -> outputs 20..27 in order, one per cycle.
- FIFO full, FLAG_IN=1 and READY=1 in the same cycle -> flag dropped, LOST_COUNT+1, FILL_LEVEL=7; next flag accepted.
- TS_WIDTH=4: flags at TS=14, 15 and the following cycle -> stored 14, 15, 0. TS_CLEAR asserted with a flag at TS=9 -> stored 9, next TS=0.
- LOST_WIDTH=2: 5 drops -> LOST_COUNT saturates at 3. LOST_CLEAR with a simultaneous drop -> LOST_COUNT=1.
- FIFO holding 3 entries, RESET for one cycle with FLAG_IN=1 -> VALID=0, FILL_LEVEL=0, LOST_COUNT=0, TS=0 afterwards. FLAG_IN with ENABLE=0 -> no entry, no loss.
